// File: rtl/ieee1500_wsp_sequencer_if.sv
// Host-side command/response channel of the IEEE 1500 WSP sequencer.
// master = test controller, slave = sequencer.
interface ieee1500_wsp_sequencer_if #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = 6
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_is_wir;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               cmd_no_upd;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;

    modport master (
        output cmd_valid, cmd_is_wir, cmd_len, cmd_data, cmd_no_upd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_is_wir, cmd_len, cmd_data, cmd_no_upd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ieee1500_wsp_sequencer.sv
// Turns host WIR/WDR scan commands into a WSP select/capture/shift/update sequence
// and returns the WSO bits collected during shift.
module ieee1500_wsp_sequencer #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = 6
) (
    input  logic                          wrck,
    input  logic                          wrstn,
    ieee1500_wsp_sequencer_if.slave       host,
    output logic                          selectwir,
    output logic                          capturewir,
    output logic                          shiftwir,
    output logic                          updatewir,
    output logic                          selectwdr,
    output logic                          capturewdr,
    output logic                          shiftwdr,
    output logic                          updatewdr,
    output logic                          wsi,
    input  logic                          wso
);

    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Control vector layout: {select, capture, shift, update}
    localparam logic [3:0] CtlOff     = 4'b0000;
    localparam logic [3:0] CtlCapture = 4'b1100;
    localparam logic [3:0] CtlShift   = 4'b1010;
    localparam logic [3:0] CtlUpdate  = 4'b1001;

    typedef enum logic [2:0] {StIdle, StCapture, StShift, StUpdate, StResp} state_e;

    state_e             state_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic [3:0]         wir_ctl_q;
    logic [3:0]         wdr_ctl_q;
    logic               wsi_q;
    logic               is_wir_q;
    logic               no_upd_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [MAX_LEN-1:0] data_q;
    logic               len_bad;

    assign len_bad = (host.cmd_len == '0) || (host.cmd_len > LEN_W'(MAX_LEN));

    // Every WSP pin comes straight from a flop, so the wrapper never sees a decode glitch.
    always_ff @(posedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            wir_ctl_q   <= CtlOff;
            wdr_ctl_q   <= CtlOff;
            wsi_q       <= 1'b0;
            is_wir_q    <= 1'b0;
            no_upd_q    <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (host.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        is_wir_q    <= host.cmd_is_wir;
                        no_upd_q    <= host.cmd_no_upd;
                        len_q       <= host.cmd_len;
                        data_q      <= host.cmd_data;
                        cnt_q       <= '0;
                        rsp_data_q  <= '0;
                        if (len_bad) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= StCapture;
                            if (host.cmd_is_wir) wir_ctl_q <= CtlCapture;
                            else                 wdr_ctl_q <= CtlCapture;
                        end
                    end
                end
                StCapture: begin
                    state_q <= StShift;
                    if (is_wir_q) wir_ctl_q <= CtlShift;
                    else          wdr_ctl_q <= CtlShift;
                    wsi_q  <= data_q[0];
                    data_q <= data_q >> 1;
                end
                StShift: begin
                    rsp_data_q[cnt_q[IdxW-1:0]] <= wso;
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        wsi_q <= 1'b0;
                        if (no_upd_q) begin
                            state_q     <= StResp;
                            wir_ctl_q   <= CtlOff;
                            wdr_ctl_q   <= CtlOff;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StUpdate;
                            if (is_wir_q) wir_ctl_q <= CtlUpdate;
                            else          wdr_ctl_q <= CtlUpdate;
                        end
                    end else begin
                        wsi_q  <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end
                StUpdate: begin
                    state_q     <= StResp;
                    wir_ctl_q   <= CtlOff;
                    wdr_ctl_q   <= CtlOff;
                    rsp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (host.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_err   = rsp_err_q;
    assign host.rsp_data  = rsp_data_q;

    assign {selectwir, capturewir, shiftwir, updatewir} = wir_ctl_q;
    assign {selectwdr, capturewdr, shiftwdr, updatewdr} = wdr_ctl_q;
    assign wsi = wsi_q;

endmodule

// File: tb/tb_ieee1500_wsp_sequencer.sv
// Directed bench for ieee1500_wsp_sequencer against a small IEEE 1500 wrapper model
// (3-bit WIR, BYPASS = 000, EXTEST = 001 selecting a 16-bit boundary register).
module tb_ieee1500_wsp_sequencer;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned LEN_W   = 6;

    logic wrck;
    logic wrstn;
    logic selectwir, capturewir, shiftwir, updatewir;
    logic selectwdr, capturewdr, shiftwdr, updatewdr;
    logic wsi;
    logic wso;

    ieee1500_wsp_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) host ();

    ieee1500_wsp_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .wrck       (wrck),
        .wrstn      (wrstn),
        .host       (host.slave),
        .selectwir  (selectwir),
        .capturewir (capturewir),
        .shiftwir   (shiftwir),
        .updatewir  (updatewir),
        .selectwdr  (selectwdr),
        .capturewdr (capturewdr),
        .shiftwdr   (shiftwdr),
        .updatewdr  (updatewdr),
        .wsi        (wsi),
        .wso        (wso)
    );

    initial begin
        wrck = 1'b0;
        forever #5 wrck = ~wrck;
    end

    // Wrapper model; deliberately not reset by wrstn so a sequencer reset leaves it untouched.
    logic [2:0]  wir     = 3'b000;
    logic [2:0]  wir_sr  = 3'b000;
    logic        byp     = 1'b0;
    logic [15:0] bsr     = 16'h0000;
    logic [15:0] wdr_upd = 16'h5A5A;

    assign wso = selectwir ? wir_sr[0] : ((wir == 3'b001) ? bsr[0] : byp);

    always @(posedge wrck) begin
        if (selectwir) begin
            if (capturewir) wir_sr <= wir;
            if (shiftwir)   wir_sr <= {wsi, wir_sr[2:1]};
            if (updatewir)  wir    <= wir_sr;
        end
        if (selectwdr) begin
            if (wir == 3'b001) begin
                if (capturewdr) bsr     <= wdr_upd;
                if (shiftwdr)   bsr     <= {wsi, bsr[15:1]};
                if (updatewdr)  wdr_upd <= bsr;
            end else begin
                if (capturewdr) byp <= 1'b0;
                if (shiftwdr)   byp <= wsi;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int upd_pulses = 0;
    int sel_cycles = 0;
    int viol = 0;
    int hold_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    // WSP protocol invariants, sampled mid-cycle.
    always @(negedge wrck) begin
        if (wrstn) begin
            if (updatewir || updatewdr) upd_pulses++;
            if (selectwir || selectwdr) sel_cycles++;
            if ($countones({capturewir, shiftwir, updatewir}) > 1) viol++;
            if ($countones({capturewdr, shiftwdr, updatewdr}) > 1) viol++;
            if (selectwir && selectwdr) viol++;
            if ((capturewir || shiftwir || updatewir) && !selectwir) viol++;
            if ((capturewdr || shiftwdr || updatewdr) && !selectwdr) viol++;
            if (wsi && !(shiftwir || shiftwdr)) viol++;
            if (host.cmd_ready && (selectwir || selectwdr)) viol++;
        end
    end

    task automatic run_cmd(input bit is_wir, input int len, input logic [31:0] data,
                           input bit no_upd, input int hold,
                           output logic [31:0] rdata, output logic rerr, output int edges);
        int waitc;
        waitc = 0;
        @(negedge wrck);
        while (!host.cmd_ready && waitc < 50) begin
            @(negedge wrck);
            waitc++;
        end
        check("rdy_idle", 32'(host.cmd_ready), 32'd1);
        host.cmd_valid  = 1'b1;
        host.cmd_is_wir = is_wir;
        host.cmd_len    = len[LEN_W-1:0];
        host.cmd_data   = data;
        host.cmd_no_upd = no_upd;
        @(posedge wrck);
        #1;
        host.cmd_valid = 1'b0;
        edges = 1;
        while (!host.rsp_valid && edges < 100) begin
            @(posedge wrck);
            #1;
            edges++;
        end
        rdata = host.rsp_data;
        rerr  = host.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge wrck);
            if (!host.rsp_valid || host.rsp_data != rdata || host.rsp_err != rerr ||
                host.cmd_ready || selectwir || capturewir || shiftwir || updatewir ||
                selectwdr || capturewdr || shiftwdr || updatewdr || wsi)
                hold_bad++;
        end
        @(negedge wrck);
        host.rsp_ready = 1'b1;
        @(posedge wrck);
        #1;
        host.rsp_ready = 1'b0;
        check("rsp_drop", 32'(host.rsp_valid), 32'd0);
        check("err_clr", 32'(host.rsp_err), 32'd0);
        check("rdy_back", 32'(host.cmd_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        re;
    int          ed;
    int          sel_before;
    int          upd_before;

    initial begin
        wrstn           = 1'b0;
        host.cmd_valid  = 1'b0;
        host.cmd_is_wir = 1'b0;
        host.cmd_len    = '0;
        host.cmd_data   = '0;
        host.cmd_no_upd = 1'b0;
        host.rsp_ready  = 1'b0;
        #1;
        check("rst_outs", {20'd0, host.cmd_ready, host.rsp_valid, host.rsp_err, selectwir,
              capturewir, shiftwir, updatewir, selectwdr, capturewdr, shiftwdr, updatewdr, wsi},
              32'd0);
        check("rst_rdata", host.rsp_data, 32'd0);
        repeat (2) @(negedge wrck);
        wrstn = 1'b1;
        @(posedge wrck);
        #1;
        check("rdy_after_rst", 32'(host.cmd_ready), 32'd1);

        // WIR <- EXTEST; BYPASS was captured.
        run_cmd(1'b1, 3, 32'h1, 1'b0, 0, rd, re, ed);
        check("t1_rdata", rd, 32'h0);
        check("t1_err", 32'(re), 32'd0);
        check("t1_lat", 32'(ed), 32'd6);
        check("t1_wir", 32'(wir), 32'h1);

        // Back to BYPASS; EXTEST code comes out.
        run_cmd(1'b1, 3, 32'h0, 1'b0, 0, rd, re, ed);
        check("t1b_rdata", rd, 32'h1);
        check("t1b_wir", 32'(wir), 32'h0);

        // WDR through the 1-bit bypass.
        run_cmd(1'b0, 4, 32'hA, 1'b0, 0, rd, re, ed);
        check("t2_rdata", rd, 32'h4);
        check("t2_lat", 32'(ed), 32'd7);
        check("t2_wdr_kept", 32'(wdr_upd), 32'h5A5A);

        // Illegal lengths: immediate error, no WSP activity.
        sel_before = sel_cycles;
        upd_before = upd_pulses;
        run_cmd(1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, rd, re, ed);
        check("t3a_err", 32'(re), 32'd1);
        check("t3a_lat", 32'(ed), 32'd1);
        check("t3a_rdata", rd, 32'h0);
        run_cmd(1'b0, MAX_LEN + 1, 32'hFFFF_FFFF, 1'b0, 0, rd, re, ed);
        check("t3b_err", 32'(re), 32'd1);
        check("t3b_lat", 32'(ed), 32'd1);
        check("t3_no_sel", 32'(sel_cycles), 32'(sel_before));
        check("t3_no_upd", 32'(upd_pulses), 32'(upd_before));

        // EXTEST, boundary write then non-destructive read with a stalled response.
        run_cmd(1'b1, 3, 32'h1, 1'b0, 0, rd, re, ed);
        check("t4_wir_rdata", rd, 32'h0);
        run_cmd(1'b0, 16, 32'hBEEF, 1'b0, 0, rd, re, ed);
        check("t4_rdata", rd, 32'h5A5A);
        check("t4_lat", 32'(ed), 32'd19);
        check("t4_wdr", 32'(wdr_upd), 32'hBEEF);
        upd_before = upd_pulses;
        run_cmd(1'b0, 16, 32'h1234, 1'b1, 5, rd, re, ed);
        check("t4_read", rd, 32'hBEEF);
        check("t4_read_lat", 32'(ed), 32'd18);
        check("t4_read_noupd", 32'(upd_pulses), 32'(upd_before));
        check("t4_read_wdr", 32'(wdr_upd), 32'hBEEF);
        check("t5_hold", 32'(hold_bad), 32'd0);

        // Reset in the middle of a WIR shift (cnt = 5).
        @(negedge wrck);
        host.cmd_valid  = 1'b1;
        host.cmd_is_wir = 1'b1;
        host.cmd_len    = 6'd8;
        host.cmd_data   = 32'hFF;
        host.cmd_no_upd = 1'b0;
        @(posedge wrck);
        #1;
        host.cmd_valid = 1'b0;
        repeat (6) @(posedge wrck);
        #1;
        check("t6_in_shift", 32'(shiftwir), 32'd1);
        upd_before = upd_pulses;
        wrstn = 1'b0;
        #1;
        check("t6_rst_outs", {20'd0, host.cmd_ready, host.rsp_valid, host.rsp_err, selectwir,
              capturewir, shiftwir, updatewir, selectwdr, capturewdr, shiftwdr, updatewdr, wsi},
              32'd0);
        repeat (2) @(negedge wrck);
        wrstn = 1'b1;
        @(posedge wrck);
        #1;
        check("t6_rdy", 32'(host.cmd_ready), 32'd1);
        check("t6_no_upd", 32'(upd_pulses), 32'(upd_before));
        check("t6_wir", 32'(wir), 32'h1);
        check("t6_no_rsp", 32'(host.rsp_valid), 32'd0);

        // Minimum length after reset: boundary bit 0 out, wsi into bit 15.
        run_cmd(1'b0, 1, 32'h1, 1'b0, 0, rd, re, ed);
        check("t7_rdata", rd, 32'h1);
        check("t7_lat", 32'(ed), 32'd4);
        check("t7_wdr", 32'(wdr_upd), 32'hDF77);

        check("invariants", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
